sky130_sram_req_ctrl: RTL

//  Request-side controller sitting directly upstream of the 1RW port (port 0) of a sky130 OpenRAM

---
 rtl/sky130_sram_req_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sky130_sram_req_ctrl.sv
// rtl/sky130_sram_req_ctrl.sv - request-side controller for the 1RW port of a sky130 OpenRAM macro
//
// Turns a valid/ready request stream into registered macro pins and collects read data
// into a small response FIFO. A read is only accepted when the FIFO plus the reads still
// in the macro pipeline leave a free slot, so the FIFO can never overflow.
//
// Optional feature: define SKY130_SRAM_REQ_CTRL_INIT_EN to zero-fill the whole RAM after reset.
//
// Ports:
//   clk, rst_n                    clock (also macro clk0), synchronous active-low reset
//   req_valid/req_ready           request handshake; req_we/req_addr/req_wdata/req_wmask payload
//   rsp_valid/rsp_ready/rsp_rdata read response stream, in request order
//   init_done                     high once the controller accepts traffic
//   sram_csb0/web0/wmask0/addr0/din0  registered macro port-0 inputs
//   sram_dout0                    macro port-0 read data
module sky130_sram_req_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 8,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  sram_csb0_q, sram_csb0_d;
    logic                  sram_web0_q, sram_web0_d;
    logic [NUM_WMASKS-1:0] sram_wmask0_q, sram_wmask0_d;
    logic [ADDR_WIDTH-1:0] sram_addr0_q, sram_addr0_d;
    logic [DATA_WIDTH-1:0] sram_din0_q, sram_din0_d;
    // bit 0: read on the pins this cycle; bit 1: macro is presenting that read's data
    logic [1:0]            rd_pipe_q, rd_pipe_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_d [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
`endif

    logic                  run;
    logic                  credit;
    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        occupancy;

    assign run       = (state_q == ST_RUN);
    // Registered count only: a pop in this cycle frees its slot from the next cycle on,
    // which keeps rsp_ready out of the req_ready path.
    assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(rd_pipe_q[0]) + (CNT_W+1)'(rd_pipe_q[1]);
    assign credit    = occupancy < (CNT_W+1)'(RSP_DEPTH);
    assign req_ready = run & (req_we | credit);
    assign req_fire  = req_valid & req_ready;
    assign push      = rd_pipe_q[1];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_mem_q[rd_ptr_q];
    assign init_done = run;

    assign sram_csb0   = sram_csb0_q;
    assign sram_web0   = sram_web0_q;
    assign sram_wmask0 = sram_wmask0_q;
    assign sram_addr0  = sram_addr0_q;
    assign sram_din0   = sram_din0_q;

    always_comb begin
        state_d       = state_q;
        sram_csb0_d   = 1'b1;
        sram_web0_d   = 1'b1;
        sram_wmask0_d = sram_wmask0_q;
        sram_addr0_d  = sram_addr0_q;
        sram_din0_d   = sram_din0_q;
        rd_pipe_d     = {rd_pipe_q[0], 1'b0};
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
        init_addr_d   = init_addr_q;
`endif

        case (state_q)
            ST_RESET: begin
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
                state_d     = ST_INIT;
                init_addr_d = '0;
`else
                state_d     = ST_RUN;
`endif
            end
            ST_INIT: begin
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
                sram_csb0_d   = 1'b0;
                sram_web0_d   = 1'b0;
                sram_wmask0_d = '1;
                sram_din0_d   = '0;
                sram_addr0_d  = init_addr_q;
                init_addr_d   = init_addr_q + 1'b1;
                if (init_addr_q == '1) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (req_fire) begin
                    sram_csb0_d  = 1'b0;
                    sram_web0_d  = ~req_we;
                    sram_addr0_d = req_addr;
                    if (req_we) begin
                        sram_din0_d   = req_wdata;
                        sram_wmask0_d = req_wmask;
                    end else begin
                        rd_pipe_d[0] = 1'b1;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            fifo_mem_d[wr_ptr_q] = sram_dout0;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            sram_csb0_q   <= 1'b1;
            sram_web0_q   <= 1'b1;
            sram_wmask0_q <= '0;
            sram_addr0_q  <= '0;
            sram_din0_q   <= '0;
            rd_pipe_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
            init_addr_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sram_csb0_q   <= sram_csb0_d;
            sram_web0_q   <= sram_web0_d;
            sram_wmask0_q <= sram_wmask0_d;
            sram_addr0_q  <= sram_addr0_d;
            sram_din0_q   <= sram_din0_d;
            rd_pipe_q     <= rd_pipe_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_mem_q    <= fifo_mem_d;
`ifdef SKY130_SRAM_REQ_CTRL_INIT_EN
            init_addr_q   <= init_addr_d;
`endif
        end
    end

    // The credit rule makes a push into a full FIFO without a matching pop unreachable.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));

endmodule
